// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - two-source in-order register-file writeback arbiter with pending-write scoreboard
//
// Purpose:
//   Accepts results from the ALU path and the memory-load path into a shared
//   in-order FIFO and drains one entry per cycle into a registered
//   register-file write port. The rs/rt busy outputs tell decode whether a
//   write to that register is still queued or in flight on the write port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   alu_valid/alu_rw/alu_dw     ALU result offer; alu_ready accepts it
//   mem_valid/mem_rw/mem_dw     load result offer; mem_ready accepts it
//   rs, rt                      decode source registers
//   rs_busy, rt_busy            write to rs/rt still pending (combinational)
//   rw, dw, rf_wr_en            registered register-file write port
//   pending                     current FIFO occupancy
module rf_writeback_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rw,
    input  logic [DATA_W-1:0]          alu_dw,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_rw,
    input  logic [DATA_W-1:0]          mem_dw,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          rs,
    input  logic [ADDR_W-1:0]          rt,
    output logic                       rs_busy,
    output logic                       rt_busy,
    output logic [ADDR_W-1:0]          rw,
    output logic [DATA_W-1:0]          dw,
    output logic                       rf_wr_en,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ZERO  = '0;
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
    localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);

    logic [ADDR_W-1:0] r_fifo_rw [DEPTH];
    logic [DATA_W-1:0] r_fifo_dw [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_dw;
    logic              r_wr_en;

    logic [CNT_W-1:0]  w_free;
    logic              w_mem_ready;
    logic              w_alu_ready;
    logic              w_mem_enq;
    logic              w_alu_enq;
    logic              w_deq;
    logic [CNT_W-1:0]  w_enq_n;
    logic [PTR_W-1:0]  w_alu_ptr;
    logic              w_rs_hit;
    logic              w_rt_hit;

    // Free space is judged on the registered count only; a pop happening in
    // the same cycle does not open a slot for an incoming result.
    assign w_free      = C_DEPTH - r_count;
    assign w_mem_ready = (w_free >= C_ONE);
    // The load path has priority on the last free slot.
    assign w_alu_ready = (w_free >= C_TWO) || ((w_free == C_ONE) && !mem_valid);

    // Register 0 handshakes complete but never occupy a slot.
    assign w_mem_enq = mem_valid && w_mem_ready && (mem_rw != '0);
    assign w_alu_enq = alu_valid && w_alu_ready && (alu_rw != '0);
    assign w_deq     = (r_count != C_ZERO);

    always_comb begin
        w_enq_n = C_ZERO;
        if (w_mem_enq) w_enq_n = w_enq_n + C_ONE;
        if (w_alu_enq) w_enq_n = w_enq_n + C_ONE;
    end

    // When both enqueue, mem takes the write pointer slot and alu the next one.
    assign w_alu_ptr = w_mem_enq ? (r_wptr + P_ONE) : r_wptr;

    // Storage needs no reset: validity comes from r_rptr/r_count alone.
    always_ff @(posedge clk) begin
        if (w_mem_enq) begin
            r_fifo_rw[r_wptr] <= mem_rw;
            r_fifo_dw[r_wptr] <= mem_dw;
        end
        if (w_alu_enq) begin
            r_fifo_rw[w_alu_ptr] <= alu_rw;
            r_fifo_dw[w_alu_ptr] <= alu_dw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rw    <= '0;
            r_dw    <= '0;
            r_wr_en <= 1'b0;
        end else begin
            // Pointer advance wraps modulo DEPTH by truncation.
            r_wptr  <= r_wptr + w_enq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - (w_deq ? C_ONE : C_ZERO);
            r_wr_en <= w_deq;
            if (w_deq) begin
                r_rptr <= r_rptr + P_ONE;
                r_rw   <= r_fifo_rw[r_rptr];
                r_dw   <= r_fifo_dw[r_rptr];
            end
        end
    end

    // Scan the valid window [r_rptr, r_rptr + r_count) for a matching destination.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                if (r_fifo_rw[r_rptr + PTR_W'(k)] == rs) w_rs_hit = 1'b1;
                if (r_fifo_rw[r_rptr + PTR_W'(k)] == rt) w_rt_hit = 1'b1;
            end
        end
        if (r_wr_en && (r_rw == rs)) w_rs_hit = 1'b1;
        if (r_wr_en && (r_rw == rt)) w_rt_hit = 1'b1;
    end

    assign rs_busy   = (rs != '0) && w_rs_hit;
    assign rt_busy   = (rt != '0) && w_rt_hit;
    assign mem_ready = w_mem_ready;
    assign alu_ready = w_alu_ready;
    assign rw        = r_rw;
    assign dw        = r_dw;
    assign rf_wr_en  = r_wr_en;
    assign pending   = r_count;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] dw;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rw = '0;
    logic [DATA_W-1:0] alu_dw = '0;
    logic              alu_ready;
    logic              mem_valid = 1'b0;
    logic [ADDR_W-1:0] mem_rw = '0;
    logic [DATA_W-1:0] mem_dw = '0;
    logic              mem_ready;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] rt = '0;
    logic              rs_busy;
    logic              rt_busy;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] dw;
    logic              rf_wr_en;
    logic [$clog2(DEPTH):0] pending;

    rf_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_dw(alu_dw), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_dw(mem_dw), .mem_ready(mem_ready),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .rw(rw), .dw(dw), .rf_wr_en(rf_wr_en), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: queue of accepted entries plus the write-port register.
    ent_t              m_q[$];
    logic              m_wr_en = 1'b0;
    logic [ADDR_W-1:0] m_rw = '0;
    logic [DATA_W-1:0] m_dw = '0;

    // Writes seen on the DUT write port (for literal expectations).
    ent_t              dut_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_busy(input logic [ADDR_W-1:0] r);
        if (r == 0) return 1'b0;
        if (m_wr_en && m_rw == r) return 1'b1;
        foreach (m_q[i]) if (m_q[i].rw == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_mem_ready();
        return (DEPTH - m_q.size()) >= 1;
    endfunction

    function automatic bit m_alu_ready(input logic mv);
        int fr;
        fr = DEPTH - m_q.size();
        return (fr >= 2) || (fr == 1 && !mv);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_wr_en = 1'b0;
            m_rw    = '0;
            m_dw    = '0;
        end else begin
            bit mr, ar;
            ent_t e;
            mr = m_mem_ready();
            ar = m_alu_ready(mem_valid);
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wr_en = 1'b1;
                m_rw    = e.rw;
                m_dw    = e.dw;
            end else begin
                m_wr_en = 1'b0;
            end
            if (mem_valid && mr && mem_rw != 0) begin
                e.rw = mem_rw; e.dw = mem_dw; m_q.push_back(e);
            end
            if (alu_valid && ar && alu_rw != 0) begin
                e.rw = alu_rw; e.dw = alu_dw; m_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ent_t e;
            chk("mem_ready", mem_ready, m_mem_ready());
            chk("alu_ready", alu_ready, m_alu_ready(mem_valid));
            chk("pending",   pending,   m_q.size());
            chk("rf_wr_en",  rf_wr_en,  m_wr_en);
            chk("rw",        rw,        m_rw);
            chk("dw",        dw,        m_dw);
            chk("rs_busy",   rs_busy,   m_busy(rs));
            chk("rt_busy",   rt_busy,   m_busy(rt));
            if (rf_wr_en) begin
                e.rw = rw; e.dw = dw; dut_log.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] wdata [10];

        rst_n = 1'b0;
        #1;
        chk("reset rf_wr_en", rf_wr_en, 1'b0);
        chk("reset pending",  pending,  0);
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("post-reset alu_ready", alu_ready, 1'b1);
        chk("post-reset mem_ready", mem_ready, 1'b1);
        chk("post-reset rw", rw, 0);
        tick();

        // Single ALU write with latency
        dut_log.delete();
        alu_valid = 1'b1; alu_rw = 5'd20; alu_dw = 32'hF5; rs = 5'd20;
        tick();                                   // edge N
        idle();
        #1 chk("single busy N", rs_busy, 1'b1);
        tick();                                   // edge N+1
        chk("single wr_en N+1", rf_wr_en, 1'b1);
        chk("single rw N+1", rw, 20);
        chk("single dw N+1", dw, 32'hF5);
        chk("single busy N+1", rs_busy, 1'b1);
        tick();                                   // edge N+2
        chk("single wr_en N+2", rf_wr_en, 1'b0);
        chk("single busy N+2", rs_busy, 1'b0);
        tick();
        chk("single log size", dut_log.size(), 1);

        // Simultaneous mem + alu to the same register
        dut_log.delete();
        rt = 5'd17;
        mem_valid = 1'b1; mem_rw = 5'd17; mem_dw = 32'd3;
        alu_valid = 1'b1; alu_rw = 5'd17; alu_dw = 32'd9;
        tick();
        idle();
        chk("simul pending", pending, 2);
        chk("simul busy 0", rt_busy, 1'b1);
        tick();
        chk("simul dw first", dw, 3);
        chk("simul busy 1", rt_busy, 1'b1);
        tick();
        chk("simul dw second", dw, 9);
        chk("simul busy 2", rt_busy, 1'b1);
        tick();
        chk("simul busy done", rt_busy, 1'b0);
        chk("simul log size", dut_log.size(), 2);

        // Fill / backpressure
        mem_valid = 1'b1; mem_rw = 5'd3; mem_dw = 32'h33;
        alu_valid = 1'b1; alu_rw = 5'd4; alu_dw = 32'h44;
        tick();
        chk("fill pending 2", pending, 2);
        tick();
        chk("fill pending 3", pending, 3);
        chk("fill3 mem_ready", mem_ready, 1'b1);
        chk("fill3 alu_ready", alu_ready, 1'b0);
        tick();
        chk("fill hold 3", pending, 3);
        mem_valid = 1'b0;
        #1 chk("fill3 alu_ready mem idle", alu_ready, 1'b1);
        idle();
        repeat (5) tick();
        chk("fill drained", pending, 0);

        // Register 0
        dut_log.delete();
        rs = '0;
        alu_valid = 1'b1; alu_rw = '0; alu_dw = 32'hDEAD;
        #1 chk("r0 alu_ready", alu_ready, 1'b1);
        tick();
        idle();
        chk("r0 pending", pending, 0);
        chk("r0 rs_busy", rs_busy, 1'b0);
        repeat (3) tick();
        chk("r0 no write", dut_log.size(), 0);

        // Wrap-around: 10 back-to-back ALU writes
        dut_log.delete();
        for (int i = 0; i < 10; i++) begin
            wdata[i]  = $urandom;
            alu_valid = 1'b1;
            alu_rw    = ADDR_W'(i + 1);
            alu_dw    = wdata[i];
            tick();
        end
        idle();
        repeat (4) tick();
        chk("wrap count", dut_log.size(), 10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
            chk("wrap rw", dut_log[i].rw, i + 1);
            chk("wrap dw", dut_log[i].dw, wdata[i]);
        end
        chk("wrap pending", pending, 0);

        // Reset mid-stream with count 3
        mem_valid = 1'b1; mem_rw = 5'd6; mem_dw = 32'h66;
        alu_valid = 1'b1; alu_rw = 5'd7; alu_dw = 32'h77;
        rs = 5'd6; rt = 5'd7;
        tick(); tick();
        chk("rst pre pending", pending, 3);
        idle();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst wr_en", rf_wr_en, 1'b0);
        chk("rst rs_busy", rs_busy, 1'b0);
        chk("rst rt_busy", rt_busy, 1'b0);
        chk("rst pending", pending, 0);
        tick(); tick();
        rst_n = 1'b1;
        dut_log.delete();
        chk_en = 1'b1;
        repeat (5) tick();
        chk("rst no stale", dut_log.size(), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            mem_valid = ($urandom_range(0, 99) < 50);
            alu_rw    = ADDR_W'($urandom_range(0, 7));
            mem_rw    = ADDR_W'($urandom_range(0, 7));
            alu_dw    = $urandom;
            mem_dw    = $urandom;
            rs        = ADDR_W'($urandom_range(0, 7));
            rt        = ADDR_W'($urandom_range(0, 7));
            tick();
        end
        idle();
        repeat (6) tick();
        chk("final pending", pending, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
